// File: rtl/t2t_crc16_stream_pkg.sv
// Shared CRC-16 definitions for the tick-to-trade datapath: CCITT constants and
// the byte-serial update used by both the streaming engine and software models.
package t2t_crc16_stream_pkg;

    typedef logic [15:0] crc16_t;

    localparam crc16_t CRC16_CCITT_POLY = 16'h1021;
    localparam crc16_t CRC16_CCITT_INIT = 16'hFFFF;

    // Fold one byte into the CRC, MSB-first, non-reflected.
    function automatic crc16_t crc16_update_byte(
        input crc16_t     crc,
        input logic [7:0] data_byte,
        input crc16_t     poly
    );
        crc16_t c;
        c = crc ^ {data_byte, 8'h00};
        for (int k = 0; k < 8; k++) begin
            if (c[15]) begin
                c = {c[14:0], 1'b0} ^ poly;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/t2t_crc16_comb.sv
// Combinational CRC-16 fold of one beat: advances the seed over every kept byte in
// ascending lane order and reports the kept-byte count and a keep-gap flag.
module t2t_crc16_comb
    import t2t_crc16_stream_pkg::*;
#(
    parameter int          DATA_BYTES = 8,
    parameter logic [15:0] POLY       = CRC16_CCITT_POLY,
    parameter int          CNT_W      = $clog2(DATA_BYTES + 1)
) (
    input  logic [15:0]             seed_i,
    input  logic [8*DATA_BYTES-1:0] data_i,
    input  logic [DATA_BYTES-1:0]   keep_i,
    output logic [15:0]             crc_next_o,
    output logic [CNT_W-1:0]        popcount_o,
    output logic                    nc_o
);

    logic [15:0]      crc_s;
    logic [CNT_W-1:0] cnt_s;

    // Unrolled per-lane fold; dropped lanes leave the CRC and count untouched.
    always_comb begin
        crc_s = seed_i;
        cnt_s = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (keep_i[i]) begin
                crc_s = crc16_update_byte(crc_s, data_i[8*i +: 8], POLY);
                cnt_s = cnt_s + CNT_W'(1);
            end else begin
                crc_s = crc_s;
                cnt_s = cnt_s;
            end
        end
    end

    assign crc_next_o = crc_s;
    assign popcount_o = cnt_s;

    // A contiguous low-aligned mask (including all-zero) has no bit in common with mask+1.
    assign nc_o = |(keep_i & (keep_i + DATA_BYTES'(1)));

endmodule

// File: rtl/t2t_crc16_stream.sv
// Streaming CRC-16 engine: one-stage AXI-Stream pass-through that reports the frame
// CRC, byte count and keep-gap flag as sideband on each tlast beat.
module t2t_crc16_stream
    import t2t_crc16_stream_pkg::*;
#(
    parameter int          DATA_BYTES = 8,
    parameter logic [15:0] POLY       = CRC16_CCITT_POLY,
    parameter logic [15:0] INIT       = CRC16_CCITT_INIT,
    parameter logic [15:0] XOR_OUT    = 16'h0000,
    parameter int          LEN_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [8*DATA_BYTES-1:0] s_axis_tdata,
    input  logic [DATA_BYTES-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [8*DATA_BYTES-1:0] m_axis_tdata,
    output logic [DATA_BYTES-1:0]   m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [15:0]             m_crc,
    output logic [LEN_W-1:0]        m_len,
    output logic                    m_keep_err
);

    localparam int CNT_W = $clog2(DATA_BYTES + 1);

    logic [15:0]      seed_s;
    logic [15:0]      crc_next_s;
    logic [CNT_W-1:0] popcount_s;
    logic             nc_s;
    logic             accept_s;
    logic [LEN_W-1:0] len_next_s;

    logic [8*DATA_BYTES-1:0] data_q, data_d;
    logic [DATA_BYTES-1:0]   keep_q, keep_d;
    logic                    last_q, last_d;
    logic                    valid_q, valid_d;
    logic [15:0]             out_crc_q, out_crc_d;
    logic [LEN_W-1:0]        out_len_q, out_len_d;
    logic                    out_err_q, out_err_d;
    logic [15:0]             crc_q, crc_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic                    err_q, err_d;
    logic                    in_frame_q, in_frame_d;

    assign s_axis_tready = !valid_q || m_axis_tready;
    assign accept_s      = s_axis_tvalid && s_axis_tready;
    assign seed_s        = in_frame_q ? crc_q : INIT;
    assign len_next_s    = len_q + LEN_W'(popcount_s);

    t2t_crc16_comb #(
        .DATA_BYTES (DATA_BYTES),
        .POLY       (POLY),
        .CNT_W      (CNT_W)
    ) u_comb (
        .seed_i     (seed_s),
        .data_i     (s_axis_tdata),
        .keep_i     (s_axis_tkeep),
        .crc_next_o (crc_next_s),
        .popcount_o (popcount_s),
        .nc_o       (nc_s)
    );

    // Next-state for the output stage and the running frame state.
    always_comb begin
        data_d     = data_q;
        keep_d     = keep_q;
        last_d     = last_q;
        valid_d    = valid_q;
        out_crc_d  = out_crc_q;
        out_len_d  = out_len_q;
        out_err_d  = out_err_q;
        crc_d      = crc_q;
        len_d      = len_q;
        err_d      = err_q;
        in_frame_d = in_frame_q;
        if (accept_s) begin
            data_d  = s_axis_tdata;
            keep_d  = s_axis_tkeep;
            last_d  = s_axis_tlast;
            valid_d = 1'b1;
            if (s_axis_tlast) begin
                out_crc_d  = crc_next_s ^ XOR_OUT;
                out_len_d  = len_next_s;
                out_err_d  = err_q | nc_s;
                crc_d      = INIT;
                len_d      = '0;
                err_d      = 1'b0;
                in_frame_d = 1'b0;
            end else begin
                out_crc_d  = 16'h0000;
                out_len_d  = '0;
                out_err_d  = 1'b0;
                crc_d      = crc_next_s;
                len_d      = len_next_s;
                err_d      = err_q | nc_s;
                in_frame_d = 1'b1;
            end
        end else if (m_axis_tready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers; reset drops any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            keep_q     <= '0;
            last_q     <= 1'b0;
            valid_q    <= 1'b0;
            out_crc_q  <= 16'h0000;
            out_len_q  <= '0;
            out_err_q  <= 1'b0;
            crc_q      <= INIT;
            len_q      <= '0;
            err_q      <= 1'b0;
            in_frame_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            keep_q     <= keep_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
            out_crc_q  <= out_crc_d;
            out_len_q  <= out_len_d;
            out_err_q  <= out_err_d;
            crc_q      <= crc_d;
            len_q      <= len_d;
            err_q      <= err_d;
            in_frame_q <= in_frame_d;
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tkeep  = keep_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tvalid = valid_q;
    assign m_crc         = out_crc_q;
    assign m_len         = out_len_q;
    assign m_keep_err    = out_err_q;

endmodule

// File: tb/tb_t2t_crc16_stream.sv
// Randomised scoreboard bench for t2t_crc16_stream: a frame-level byte-queue model
// predicts every output beat; a negedge monitor pops and compares on each handshake.
module tb_t2t_crc16_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [15:0] m_crc;
    logic [15:0] m_len;
    logic        m_keep_err;

    logic [63:0] s2_tdata;
    logic [7:0]  s2_tkeep;
    logic        s2_tlast;
    logic        s2_tvalid;
    logic        s2_tready;
    logic [63:0] m2_tdata;
    logic [7:0]  m2_tkeep;
    logic        m2_tlast;
    logic        m2_tvalid;
    logic [15:0] m2_crc;
    logic [15:0] m2_len;
    logic        m2_keep_err;

    always #5 clk = ~clk;

    t2t_crc16_stream dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_crc         (m_crc),
        .m_len         (m_len),
        .m_keep_err    (m_keep_err)
    );

    t2t_crc16_stream #(.XOR_OUT(16'hFFFF)) dut_x (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s2_tdata),
        .s_axis_tkeep  (s2_tkeep),
        .s_axis_tlast  (s2_tlast),
        .s_axis_tvalid (s2_tvalid),
        .s_axis_tready (s2_tready),
        .m_axis_tdata  (m2_tdata),
        .m_axis_tkeep  (m2_tkeep),
        .m_axis_tlast  (m2_tlast),
        .m_axis_tvalid (m2_tvalid),
        .m_axis_tready (1'b1),
        .m_crc         (m2_crc),
        .m_len         (m2_len),
        .m_keep_err    (m2_keep_err)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [15:0] crc;
        logic [15:0] len;
        logic        err;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] frame_q[$];
    logic       model_err;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_acc_cyc = 0;
    int         frames_seen = 0;
    logic [15:0] last_crc;
    logic [15:0] last_len;
    logic        last_err;
    bit          stall_mode = 1'b0;
    bit          rand_mode = 1'b0;

    // Bit-serial CRC-16/CCITT over the whole buffered frame.
    function automatic logic [15:0] ref_crc();
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (frame_q[n]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ frame_q[n][b];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    function automatic bit keep_gap(input logic [7:0] k);
        bit seen0;
        seen0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!k[i]) seen0 = 1'b1;
            else if (seen0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_accept(input logic [63:0] d, input logic [7:0] k, input logic l);
        exp_t e;
        e.data = d;
        e.keep = k;
        e.last = l;
        for (int i = 0; i < 8; i++) if (k[i]) frame_q.push_back(d[8*i +: 8]);
        model_err = model_err | keep_gap(k);
        if (l) begin
            e.crc = ref_crc();
            e.len = 16'(frame_q.size());
            e.err = model_err;
            frame_q.delete();
            model_err = 1'b0;
        end else begin
            e.crc = 16'h0000;
            e.len = 16'h0000;
            e.err = 1'b0;
        end
        sb.push_back(e);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output-ready pattern generator; changes just after each rising edge.
    initial begin
        int phase;
        phase = 0;
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode) begin
                phase = (phase + 1) % 4;
                m_axis_tready = (phase == 0);
            end else if (rand_mode) begin
                m_axis_tready = ($urandom_range(0, 3) != 0);
            end else begin
                m_axis_tready = 1'b1;
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat got data=%h keep=%h last=%b, none expected",
                         m_axis_tdata, m_axis_tkeep, m_axis_tlast);
            end else begin
                e = sb.pop_front();
                if (m_axis_tdata !== e.data || m_axis_tkeep !== e.keep || m_axis_tlast !== e.last ||
                    m_crc !== e.crc || m_len !== e.len || m_keep_err !== e.err) begin
                    errors++;
                    $display("FAIL beat got data=%h keep=%h last=%b crc=%h len=%0d err=%b want data=%h keep=%h last=%b crc=%h len=%0d err=%b",
                             m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_crc, m_len, m_keep_err,
                             e.data, e.keep, e.last, e.crc, e.len, e.err);
                end
            end
            if (m_axis_tlast) begin
                last_crc = m_crc;
                last_len = m_len;
                last_err = m_keep_err;
                frames_seen++;
            end
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        bit rdy;
        int w;
        rdy = 1'b0;
        w = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (!rdy && w < 200) begin
            @(negedge clk);
            rdy = s_axis_tready;
            @(posedge clk);
            #1;
            w++;
        end
        s_axis_tvalid = 1'b0;
        if (rdy) begin
            model_accept(d, k, l);
            last_acc_cyc = cyc;
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got tready=0 for %0d cycles, want acceptance", w);
        end
    endtask

    task automatic send_123();
        logic [63:0] d1;
        d1 = {$urandom, $urandom};
        d1[7:0] = 8'h39;
        send_beat(64'h3837363534333231, 8'hFF, 1'b0);
        send_beat(d1, 8'h01, 1'b1);
    endtask

    task automatic wait_frames(input int n);
        int w;
        w = 0;
        while (frames_seen < n && w < 500) begin
            @(posedge clk);
            w++;
        end
        #1;
        if (frames_seen < n) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout got %0d frames, want %0d", frames_seen, n);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got no finish, want completion");
        $fatal(1);
    end

    initial begin
        int f;
        int t0;
        int nb;
        logic [63:0] d;
        logic [7:0]  k;

        rst_n = 1'b0;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
        s2_tdata = '0; s2_tkeep = '0; s2_tlast = 1'b0; s2_tvalid = 1'b0;
        model_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_outputs",
                  32'({m_axis_tvalid, |m_axis_tdata, |m_axis_tkeep, m_axis_tlast, |m_crc, |m_len, m_keep_err}),
                  32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // XOR_OUT=FFFF instance over "123456789".
        s2_tdata = 64'h3837363534333231; s2_tkeep = 8'hFF; s2_tlast = 1'b0; s2_tvalid = 1'b1;
        @(posedge clk); #1;
        s2_tdata = 64'h0000000000000039; s2_tkeep = 8'h01; s2_tlast = 1'b1;
        @(posedge clk); #1;
        s2_tvalid = 1'b0;
        @(negedge clk);
        check_val("xorout_last", 32'({m2_tvalid, m2_tlast, m2_keep_err}), 32'b110);
        check_val("xorout_crc", 32'(m2_crc), 32'h0000D64E);
        check_val("xorout_len", 32'(m2_len), 32'd9);
        @(posedge clk); #1;

        // Check value "123456789".
        f = frames_seen;
        send_123();
        wait_frames(f + 1);
        check_val("t1_crc", 32'(last_crc), 32'h000029B1);
        check_val("t1_len", 32'(last_len), 32'd9);
        check_val("t1_err", 32'(last_err), 32'd0);

        // Two frames back-to-back with no idle cycle.
        f = frames_seen;
        send_beat(64'h3837363534333231, 8'hFF, 1'b0);
        t0 = last_acc_cyc;
        send_beat(64'h0000000000000039, 8'h01, 1'b1);
        send_123();
        check_val("t2_no_bubble", 32'(last_acc_cyc - t0), 32'd3);
        wait_frames(f + 2);
        check_val("t2_crc", 32'(last_crc), 32'h000029B1);

        // 64-byte record with 3-cycle output stalls.
        f = frames_seen;
        stall_mode = 1'b1;
        for (int b = 0; b < 8; b++) send_beat({$urandom, $urandom}, 8'hFF, b == 7);
        wait_frames(f + 1);
        stall_mode = 1'b0;
        check_val("t3_len", 32'(last_len), 32'd64);

        // Non-contiguous keep inside a frame, then a clean frame.
        f = frames_seen;
        send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        send_beat({$urandom, $urandom}, 8'h05, 1'b0);
        send_beat({$urandom, $urandom}, 8'h03, 1'b1);
        wait_frames(f + 1);
        check_val("t4_err", 32'(last_err), 32'd1);
        check_val("t4_len", 32'(last_len), 32'd12);
        send_123();
        wait_frames(f + 2);
        check_val("t4_next_err", 32'(last_err), 32'd0);

        // Reset in the middle of a frame.
        repeat (3) @(posedge clk);
        #1;
        check_val("t5_sb_drained", 32'(sb.size()), 32'd0);
        send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        frame_q.delete();
        model_err = 1'b0;
        @(negedge clk);
        check_val("t5_reset_outputs",
                  32'({m_axis_tvalid, |m_axis_tdata, |m_axis_tkeep, m_axis_tlast, |m_crc, |m_len, m_keep_err}),
                  32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        f = frames_seen;
        send_123();
        wait_frames(f + 1);
        check_val("t5_crc", 32'(last_crc), 32'h000029B1);
        check_val("t5_len", 32'(last_len), 32'd9);

        // Randomised frames with random output back-pressure.
        rand_mode = 1'b1;
        for (int fr = 0; fr < 40; fr++) begin
            nb = $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) begin
                d = {$urandom, $urandom};
                k = ($urandom_range(0, 9) < 7) ? 8'hFF : 8'($urandom);
                send_beat(d, k, b == nb - 1);
            end
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rand_mode = 1'b0;
        for (int w = 0; w < 200 && sb.size() != 0; w++) @(posedge clk);
        #1;
        check_val("drain_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
